// File: rtl/vga_pkg.sv
// Shared constants, motion state type and bounce helper
// for the VGA box renderer.
package vga_pkg;

    localparam int unsigned H_ACTIVE  = 640;
    localparam int unsigned V_ACTIVE  = 480;
    localparam int unsigned BOX_SIZE  = 32;
    localparam logic [7:0]  BOX_COLOR = 8'hE0;
    localparam logic [7:0]  BG_COLOR  = 8'h03;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } motion_state_e;

    // One step along an axis; returns {dir, pos}.
    // Reflection happens on the limit itself, so the box never wraps.
    function automatic logic [10:0] bounce_step(
        input logic [9:0] pos,
        input logic       dir,
        input logic [9:0] lim
    );
        logic [10:0] r;
        if (dir && pos >= lim) begin
            r = {1'b0, pos - 10'd1};
        end else if (!dir && pos == 10'd0) begin
            r = {1'b1, 10'd1};
        end else if (dir) begin
            r = {1'b1, pos + 10'd1};
        end else begin
            r = {1'b0, pos - 10'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_box_renderer_if.sv
// Beam position and sync bus coming from the VGA timing
// controller into the renderer.
interface vga_box_renderer_if;

    logic [9:0] X_Axis;
    logic [9:0] Y_Axis;
    logic       H_SYNC;
    logic       V_SYNC;

    modport master (
        output X_Axis,
        output Y_Axis,
        output H_SYNC,
        output V_SYNC
    );

    modport slave (
        input X_Axis,
        input Y_Axis,
        input H_SYNC,
        input V_SYNC
    );

endinterface

// File: rtl/vga_box_motion.sv
// Box position/direction FSM: steps the box one pixel per
// frame tick while running, bouncing off the active-area edges.
module vga_box_motion
    import vga_pkg::*;
#(
    parameter logic [9:0] MAX_X = 10'd608,
    parameter logic [9:0] MAX_Y = 10'd448,
    parameter logic [9:0] RST_X = 10'd304,
    parameter logic [9:0] RST_Y = 10'd224
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Frame_Tick,
    input  logic       Pause,
    output logic [9:0] Box_X,
    output logic [9:0] Box_Y
);

    motion_state_e state_q, state_d;
    logic [9:0]    box_x_q, box_x_d;
    logic [9:0]    box_y_q, box_y_d;
    logic          dir_x_q, dir_x_d;
    logic          dir_y_q, dir_y_d;
    logic          move;
    logic [10:0]   step_x;
    logic [10:0]   step_y;

    // Next state and position; a tick that coincides with Pause
    // is ignored even if the state register still reads RUN.
    always_comb begin
        state_d = Pause ? HOLD : RUN;
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        move    = Frame_Tick && (state_q == RUN) && !Pause;
        step_x  = bounce_step(box_x_q, dir_x_q, MAX_X);
        step_y  = bounce_step(box_y_q, dir_y_q, MAX_Y);
        if (move) begin
            {dir_x_d, box_x_d} = step_x;
            {dir_y_d, box_y_d} = step_y;
        end
    end

    // State, position and direction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            box_x_q <= RST_X;
            box_y_q <= RST_Y;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
        end else begin
            state_q <= state_d;
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
        end
    end

    assign Box_X = box_x_q;
    assign Box_Y = box_y_q;

endmodule

// File: rtl/vga_box_renderer.sv
// Bouncing-box pixel generator: one-clock registered colour
// and delayed syncs, plus a frame tick from falling V_SYNC.
module vga_box_renderer #(
    parameter int unsigned H_ACTIVE  = vga_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE  = vga_pkg::V_ACTIVE,
    parameter int unsigned BOX_SIZE  = vga_pkg::BOX_SIZE,
    parameter logic [7:0]  BOX_COLOR = vga_pkg::BOX_COLOR,
    parameter logic [7:0]  BG_COLOR  = vga_pkg::BG_COLOR
) (
    input  logic                clk,
    input  logic                rst,
    vga_box_renderer_if.slave   vga,
    input  logic                Pause,
    output logic [7:0]          RGB,
    output logic                H_SYNC_OUT,
    output logic                V_SYNC_OUT,
    output logic                Frame_Tick
);

    localparam logic [9:0]  H_LIM = 10'(H_ACTIVE);
    localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);
    localparam logic [10:0] BOX_W = 11'(BOX_SIZE);
    localparam logic [9:0]  MAX_X = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  MAX_Y = 10'(V_ACTIVE - BOX_SIZE);
    localparam logic [9:0]  RST_X = 10'((H_ACTIVE - BOX_SIZE) / 2);
    localparam logic [9:0]  RST_Y = 10'((V_ACTIVE - BOX_SIZE) / 2);

    logic [7:0] rgb_q, rgb_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       tick_q, tick_d;
    logic [9:0] box_x;
    logic [9:0] box_y;
    logic       vis;
    logic       hit_x;
    logic       hit_y;

    vga_box_motion #(
        .MAX_X (MAX_X),
        .MAX_Y (MAX_Y),
        .RST_X (RST_X),
        .RST_Y (RST_Y)
    ) u_motion (
        .clk        (clk),
        .rst        (rst),
        .Frame_Tick (tick_q),
        .Pause      (Pause),
        .Box_X      (box_x),
        .Box_Y      (box_y)
    );

    // Pixel colour, sync delay and V_SYNC falling-edge detect.
    always_comb begin
        vis    = (vga.X_Axis < H_LIM) && (vga.Y_Axis < V_LIM);
        hit_x  = (vga.X_Axis >= box_x)
              && ({1'b0, vga.X_Axis} < ({1'b0, box_x} + BOX_W));
        hit_y  = (vga.Y_Axis >= box_y)
              && ({1'b0, vga.Y_Axis} < ({1'b0, box_y} + BOX_W));
        rgb_d  = 8'h00;
        if (vis) begin
            rgb_d = (hit_x && hit_y) ? BOX_COLOR : BG_COLOR;
        end
        hs_d   = vga.H_SYNC;
        vs_d   = vga.V_SYNC;
        tick_d = vs_q && !vga.V_SYNC;
    end

    // Output registers; vs_q doubles as the previous-V_SYNC copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q  <= 8'h00;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            rgb_q  <= rgb_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            tick_q <= tick_d;
        end
    end

    assign RGB        = rgb_q;
    assign H_SYNC_OUT = hs_q;
    assign V_SYNC_OUT = vs_q;
    assign Frame_Tick = tick_q;

endmodule

// File: tb/tb_vga_box_renderer.sv
// Directed bench for vga_box_renderer: pixel map, ticks,
// bounce, pause and mid-frame reset.
module tb_vga_box_renderer;

    logic       clk;
    logic       rst;
    logic       Pause;
    logic [7:0] RGB;
    logic       H_SYNC_OUT;
    logic       V_SYNC_OUT;
    logic       Frame_Tick;

    int n_chk;
    int n_fail;
    int pulses;

    vga_box_renderer_if vga ();

    vga_box_renderer dut (
        .clk        (clk),
        .rst        (rst),
        .vga        (vga.slave),
        .Pause      (Pause),
        .RGB        (RGB),
        .H_SYNC_OUT (H_SYNC_OUT),
        .V_SYNC_OUT (V_SYNC_OUT),
        .Frame_Tick (Frame_Tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One frame tick: V_SYNC low for 2 clk then high for 1 clk.
    task automatic tick();
        vga.V_SYNC = 1'b0;
        step();
        if (Frame_Tick) pulses++;
        step();
        if (Frame_Tick) pulses++;
        vga.V_SYNC = 1'b1;
        step();
        if (Frame_Tick) pulses++;
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y,
                       input logic [7:0] exp, input string tag);
        vga.X_Axis = x;
        vga.Y_Axis = y;
        step();
        chk(tag, {24'd0, RGB}, {24'd0, exp});
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        pulses     = 0;
        rst        = 1'b1;
        Pause      = 1'b0;
        vga.X_Axis = 10'd0;
        vga.Y_Axis = 10'd0;
        vga.H_SYNC = 1'b0;
        vga.V_SYNC = 1'b0;

        repeat (3) step();
        chk("rst_rgb", {24'd0, RGB}, 32'h00);
        chk("rst_hs", {31'd0, H_SYNC_OUT}, 32'd1);
        chk("rst_vs", {31'd0, V_SYNC_OUT}, 32'd1);
        chk("rst_tick", {31'd0, Frame_Tick}, 32'd0);
        chk("rst_bx", {22'd0, dut.box_x}, 32'd304);
        chk("rst_by", {22'd0, dut.box_y}, 32'd224);

        vga.H_SYNC = 1'b1;
        vga.V_SYNC = 1'b1;
        rst = 1'b0;
        pix(10'd310, 10'd230, 8'hE0, "pix_box");
        pix(10'd100, 10'd100, 8'h03, "pix_bg");
        pix(10'd700, 10'd100, 8'h00, "pix_hblank");
        pix(10'd100, 10'd500, 8'h00, "pix_vblank");
        pix(10'd303, 10'd230, 8'h03, "pix_left_out");
        pix(10'd335, 10'd255, 8'hE0, "pix_last_in");
        pix(10'd336, 10'd255, 8'h03, "pix_right_out");
        pix(10'd639, 10'd479, 8'h03, "pix_corner_vis");
        pix(10'd640, 10'd479, 8'h00, "pix_edge_blank");

        vga.H_SYNC = 1'b0;
        step();
        chk("hs_delay", {31'd0, H_SYNC_OUT}, 32'd0);
        vga.H_SYNC = 1'b1;

        vga.V_SYNC = 1'b0;
        step();
        chk("tick_hi", {31'd0, Frame_Tick}, 32'd1);
        chk("tick_vs_out", {31'd0, V_SYNC_OUT}, 32'd0);
        step();
        chk("tick_lo", {31'd0, Frame_Tick}, 32'd0);
        chk("move_bx", {22'd0, dut.box_x}, 32'd305);
        chk("move_by", {22'd0, dut.box_y}, 32'd225);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (Frame_Tick) pulses++;
        end
        chk("no_retick", pulses, 32'd0);
        vga.V_SYNC = 1'b1;
        step();

        Pause = 1'b1;
        step();
        pulses = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("pause_pulses", pulses, 32'd5);
        chk("pause_bx", {22'd0, dut.box_x}, 32'd305);
        chk("pause_by", {22'd0, dut.box_y}, 32'd225);
        Pause = 1'b0;
        step();
        tick();
        chk("resume_bx", {22'd0, dut.box_x}, 32'd306);
        chk("resume_by", {22'd0, dut.box_y}, 32'd226);

        force dut.u_motion.box_x_q = 10'd608;
        force dut.u_motion.dir_x_q = 1'b1;
        step();
        release dut.u_motion.box_x_q;
        release dut.u_motion.dir_x_q;
        tick();
        chk("right_bx", {22'd0, dut.box_x}, 32'd607);
        chk("right_dx", {31'd0, dut.u_motion.dir_x_q}, 32'd0);

        force dut.u_motion.box_x_q = 10'd0;
        force dut.u_motion.dir_x_q = 1'b0;
        force dut.u_motion.box_y_q = 10'd0;
        force dut.u_motion.dir_y_q = 1'b0;
        step();
        release dut.u_motion.box_x_q;
        release dut.u_motion.dir_x_q;
        release dut.u_motion.box_y_q;
        release dut.u_motion.dir_y_q;
        tick();
        chk("left_bx", {22'd0, dut.box_x}, 32'd1);
        chk("left_dx", {31'd0, dut.u_motion.dir_x_q}, 32'd1);
        chk("top_by", {22'd0, dut.box_y}, 32'd1);
        chk("top_dy", {31'd0, dut.u_motion.dir_y_q}, 32'd1);

        force dut.u_motion.box_x_q = 10'd608;
        force dut.u_motion.dir_x_q = 1'b1;
        force dut.u_motion.box_y_q = 10'd448;
        force dut.u_motion.dir_y_q = 1'b1;
        step();
        release dut.u_motion.box_x_q;
        release dut.u_motion.dir_x_q;
        release dut.u_motion.box_y_q;
        release dut.u_motion.dir_y_q;
        tick();
        chk("corner_bx", {22'd0, dut.box_x}, 32'd607);
        chk("corner_by", {22'd0, dut.box_y}, 32'd447);
        chk("corner_dx", {31'd0, dut.u_motion.dir_x_q}, 32'd0);
        chk("corner_dy", {31'd0, dut.u_motion.dir_y_q}, 32'd0);
        tick();
        chk("after_corner_bx", {22'd0, dut.box_x}, 32'd606);
        chk("after_corner_by", {22'd0, dut.box_y}, 32'd446);

        for (int i = 0; i < 3; i++) tick();
        chk("pre_rst_bx", {22'd0, dut.box_x}, 32'd603);
        pulses = 0;
        rst = 1'b1;
        vga.V_SYNC = 1'b0;
        step();
        if (Frame_Tick) pulses++;
        chk("mid_rst_bx", {22'd0, dut.box_x}, 32'd304);
        chk("mid_rst_by", {22'd0, dut.box_y}, 32'd224);
        chk("mid_rst_rgb", {24'd0, RGB}, 32'h00);
        chk("mid_rst_vs", {31'd0, V_SYNC_OUT}, 32'd1);
        step();
        if (Frame_Tick) pulses++;
        vga.V_SYNC = 1'b1;
        step();
        if (Frame_Tick) pulses++;
        rst = 1'b0;
        vga.H_SYNC = 1'b0;
        vga.X_Axis = 10'd310;
        vga.Y_Axis = 10'd230;
        step();
        if (Frame_Tick) pulses++;
        chk("mid_rst_no_tick", pulses, 32'd0);
        chk("post_rst_hs", {31'd0, H_SYNC_OUT}, 32'd0);
        chk("post_rst_vs", {31'd0, V_SYNC_OUT}, 32'd1);
        chk("post_rst_rgb", {24'd0, RGB}, 32'hE0);
        chk("post_rst_bx", {22'd0, dut.box_x}, 32'd304);
        vga.H_SYNC = 1'b1;
        vga.V_SYNC = 1'b0;
        step();
        chk("post_rst_hs2", {31'd0, H_SYNC_OUT}, 32'd1);
        chk("post_rst_vs2", {31'd0, V_SYNC_OUT}, 32'd0);
        chk("post_rst_tick", {31'd0, Frame_Tick}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_box_renderer.md
VGA_BOX_RENDERER -- requirements
Module: vga_box_renderer

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-003 Parameter BOX_SIZE, 32, box edge length in pixels.
REQ-004 Parameter BOX_COLOR, 8'hE0, RGB 3-3-2 colour inside the box; BG_COLOR, 8'h03, colour elsewhere in the visible area.
REQ-005 The block SHALL use one clock, clk; rst SHALL be synchronous and active-high.
REQ-006 clk  input  1  system clock, same clock as the upstream VGA_Controller.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 X_Axis  input  10  current column from VGA_Controller, 0..799.
REQ-009 Y_Axis  input  10  current line from VGA_Controller, 0..524.
REQ-010 H_SYNC, V_SYNC  input  1 each  active-low syncs from VGA_Controller.
REQ-011 Pause  input  1  high freezes box motion.
REQ-012 RGB  output  8  registered pixel colour, R[7:5] G[4:2] B[1:0].
REQ-013 H_SYNC_OUT, V_SYNC_OUT  output  1 each  syncs delayed to align with RGB.
REQ-014 Frame_Tick  output  1  one-cycle pulse per frame.

Function
REQ-015 Latency: RGB, H_SYNC_OUT and V_SYNC_OUT SHALL be registered and reflect the X_Axis/Y_Axis/syncs sampled exactly 1 clk earlier.
REQ-016 Blanking: RGB SHALL be 8'h00 when X_Axis >= H_ACTIVE or Y_Axis >= V_ACTIVE.
REQ-017 Box hit: RGB SHALL be BOX_COLOR when Box_X <= X_Axis < Box_X+BOX_SIZE and Box_Y <= Y_Axis < Box_Y+BOX_SIZE. Otherwise, in the visible area, RGB SHALL be BG_COLOR.
REQ-018 Frame tick: a registered copy of V_SYNC SHALL be kept. Frame_Tick SHALL pulse for one clk when the previous V_SYNC is 1 and the current V_SYNC is 0.
REQ-019 The motion FSM SHALL have states RUN and HOLD. RUN->HOLD when Pause=1, HOLD->RUN when Pause=0; the state SHALL be evaluated every clk.
REQ-020 Box_X and Box_Y SHALL change only on Frame_Tick while in RUN. They SHALL be 10 bits wide and unsigned, and each SHALL step 1 pixel per tick in direction Dir_X (1=right) or Dir_Y (1=down).
REQ-021 Right/bottom edge: when Dir_X=1 and Box_X == H_ACTIVE-BOX_SIZE, Box_X SHALL move to Box_X-1 and Dir_X SHALL clear in the same tick. The bottom edge SHALL be handled the same way with V_ACTIVE.
REQ-022 Left/top edge: when Dir_X=0 and Box_X == 0, Box_X SHALL move to 1 and Dir_X SHALL set in the same tick. The top edge SHALL be handled the same way.
REQ-023 A corner hit SHALL reflect both axes in the same tick. Box_X SHALL always lie in 0..H_ACTIVE-BOX_SIZE and Box_Y in 0..V_ACTIVE-BOX_SIZE; the box never wraps.
REQ-024 When Pause=1 and Frame_Tick coincide, the box SHALL NOT move, and Frame_Tick SHALL still pulse.
REQ-025 Position updates SHALL take effect for pixels sampled on the clk after the tick, so a visible frame never shows a torn box.

Reset
REQ-026 On rst=1 at a clk edge: RGB=8'h00, H_SYNC_OUT=1, V_SYNC_OUT=1, Frame_Tick=0, previous-V_SYNC register=1, state=RUN, Box_X=304, Box_Y=224, Dir_X=1, Dir_Y=1.
REQ-027 A reset asserted mid-frame SHALL take effect on the same edge, with no pending tick or move surviving. Rendering SHALL resume on the first clk after rst falls.

Structure
REQ-028 H_ACTIVE, V_ACTIVE, BOX_SIZE, the colour constants and the motion state enumeration SHALL live in the shared package vga_pkg.
REQ-029 The position/direction FSM SHALL be the sub-module vga_box_motion, with inputs clk, rst, Frame_Tick, Pause and outputs Box_X, Box_Y. The pixel compare and the output registers SHALL stay in the top level.

Verification
REQ-030 Reset: hold rst 3 clk -> RGB=00, H_SYNC_OUT=V_SYNC_OUT=1, Frame_Tick=0, internal Box=(304,224).
REQ-031 Pixel map: drive X=310,Y=230 -> RGB=E0 1 clk later; X=100,Y=100 -> 03; X=700,Y=100 -> 00; X=100,Y=500 -> 00.
REQ-032 Tick and move: drive V_SYNC 1->0 -> Frame_Tick high exactly 1 clk and Box=(305,225). Hold V_SYNC low 10 clk -> no further tick.
REQ-033 Bounce: preload Box_X=608 with Dir_X=1 and tick -> Box_X=607, Dir_X=0. Box_X=0 with Dir_X=0 and tick -> Box_X=1, Dir_X=1. Corner (608,448) -> (607,447) with both directions flipped.
REQ-034 Pause: Pause=1 across 5 ticks -> Box unchanged and 5 Frame_Tick pulses. Release Pause and tick -> the box moves 1 px.
REQ-035 Mid-frame reset: after 3 ticks assert rst with V_SYNC falling on the same clk -> no tick, Box=(304,224), H_SYNC_OUT/V_SYNC_OUT follow the inputs with 1-clk delay after release.
